// File: rtl/bilinear_interp.sv
// rtl/bilinear_interp.sv - three-stage bilinear pixel interpolator with AXI-style output framing
module bilinear_interp #(
  parameter int img_width  = 640,
  parameter int img_height = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lu,
  input  logic [7:0] ru,
  input  logic [7:0] ld,
  input  logic [7:0] rd,
  input  logic [5:0] xfrac,
  input  logic [5:0] yfrac,
  input  logic       ptvalid,
  input  logic       ptlast,
  output logic       ptready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic       frame_done,
  output logic       frame_err
);
  localparam int xw = (img_width > 1) ? $clog2(img_width) : 1;
  localparam int yw = (img_height > 1) ? $clog2(img_height) : 1;
  localparam logic [xw-1:0] x_max = xw'(img_width - 1);
  localparam logic [yw-1:0] y_max = yw'(img_height - 1);

  logic        s1_valid_q, s1_valid_d;
  logic [13:0] s1_top_q, s1_top_d;
  logic [13:0] s1_bot_q, s1_bot_d;
  logic [5:0]  s1_yfrac_q, s1_yfrac_d;
  logic        s1_last_q, s1_last_d;
  logic        s2_valid_q, s2_valid_d;
  logic [19:0] s2_v_q, s2_v_d;
  logic        s2_last_q, s2_last_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic [xw-1:0] x_q, x_d;
  logic [yw-1:0] y_q, y_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic       en;
  logic       xfer;
  logic [6:0] wx;
  logic [6:0] wy;

  always_comb begin
    en   = !out_valid_q || m_tready;
    xfer = out_valid_q && m_tready;
    wx   = 7'd64 - {1'b0, xfrac};
    wy   = 7'd64 - {1'b0, s1_yfrac_q};

    s1_valid_d  = s1_valid_q;
    s1_top_d    = s1_top_q;
    s1_bot_d    = s1_bot_q;
    s1_yfrac_d  = s1_yfrac_q;
    s1_last_d   = s1_last_q;
    s2_valid_d  = s2_valid_q;
    s2_v_d      = s2_v_q;
    s2_last_d   = s2_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    // All stages move together; a stalled output freezes the whole pipe.
    if (en) begin
      s1_valid_d  = ptvalid;
      s1_top_d    = 14'(lu) * 14'(wx) + 14'(ru) * 14'(xfrac);
      s1_bot_d    = 14'(ld) * 14'(wx) + 14'(rd) * 14'(xfrac);
      s1_yfrac_d  = yfrac;
      s1_last_d   = ptlast;
      s2_valid_d  = s1_valid_q;
      s2_v_d      = 20'(s1_top_q) * 20'(wy) + 20'(s1_bot_q) * 20'(s1_yfrac_q);
      s2_last_d   = s1_last_q;
      out_valid_d = s2_valid_q;
      out_data_d  = 8'((s2_v_q + 20'd2048) >> 12);
      out_last_d  = s2_last_q;
    end

    x_d    = x_q;
    y_d    = y_q;
    done_d = 1'b0;
    err_d  = err_q;
    // ptlast always ends the frame; a mismatch with the counted size is flagged either way.
    if (xfer) begin
      if (out_last_q) begin
        x_d    = '0;
        y_d    = '0;
        done_d = 1'b1;
        if (!(x_q == x_max && y_q == y_max)) err_d = 1'b1;
      end else if (x_q == x_max) begin
        x_d = '0;
        if (y_q == y_max) begin
          y_d   = '0;
          err_d = 1'b1;
        end else begin
          y_d = y_q + yw'(1);
        end
      end else begin
        x_d = x_q + xw'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_top_q    <= '0;
      s1_bot_q    <= '0;
      s1_yfrac_q  <= '0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_v_q      <= '0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_top_q    <= s1_top_d;
      s1_bot_q    <= s1_bot_d;
      s1_yfrac_q  <= s1_yfrac_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_v_q      <= s2_v_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      x_q         <= x_d;
      y_q         <= y_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ptready    = en;
  assign m_tvalid   = out_valid_q;
  assign m_tdata    = out_data_q;
  assign m_tlast    = (x_q == x_max);
  assign m_tuser    = (x_q == '0) && (y_q == '0);
  assign frame_done = done_q;
  assign frame_err  = err_q;
endmodule
